// File: rtl/draw_scheduler.sv
// Command FIFO plus one-at-a-time dispatcher for the fill/circle/reuleaux engines,
// muxing the active engine's pixels onto the VGA port. Optional: PLOT_CLIP_EN.
module draw_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ARM_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_engine,
  input  logic [2:0]  cmd_colour,
  input  logic [7:0]  cmd_cx,
  input  logic [6:0]  cmd_cy,
  input  logic [7:0]  cmd_diameter,
  output logic [2:0]  eng_start,
  input  logic [2:0]  eng_done,
  output logic [2:0]  eng_colour,
  output logic [7:0]  eng_cx,
  output logic [6:0]  eng_cy,
  output logic [7:0]  eng_diameter,
  input  logic [23:0] eng_vga_x,
  input  logic [20:0] eng_vga_y,
  input  logic [8:0]  eng_vga_colour,
  input  logic [2:0]  eng_vga_plot,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic        busy,
  output logic        idle,
  output logic        cmd_retired
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (ARM_CYCLES < 2) ? 1 : $clog2(ARM_CYCLES + 1);
  localparam int EW = 28;

  typedef enum logic [2:0] {IDLE, LAUNCH, ARM, WAIT, RETIRE} state_t;

  state_t state, next_state;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;
  logic [1:0]    head_engine;

  logic [CW-1:0] arm_cnt;
  logic [1:0]    act_engine;
  logic          act_done;

  logic [7:0]    mux_x;
  logic [6:0]    mux_y;
  logic [2:0]    mux_colour;
  logic          mux_plot;

  assign full        = (count == (AW + 1)'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign cmd_ready   = !full;
  assign push        = cmd_valid && !full;
  assign head        = mem[rd_ptr];
  assign head_engine = head[27:26];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_engine, cmd_colour, cmd_cx, cmd_cy, cmd_diameter};
  end

  // Pointers rely on power-of-two depth to wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      arm_cnt      <= '0;
      act_engine   <= '0;
      eng_colour   <= '0;
      eng_cx       <= '0;
      eng_cy       <= '0;
      eng_diameter <= '0;
    end else begin
      state <= next_state;
      if (pop) begin
        act_engine   <= head_engine;
        eng_colour   <= head[25:23];
        eng_cx       <= head[22:15];
        eng_cy       <= head[14:8];
        eng_diameter <= head[7:0];
      end
      if (state == LAUNCH)
        arm_cnt <= CW'(ARM_CYCLES);
      else if (state == ARM && arm_cnt != '0)
        arm_cnt <= arm_cnt - 1'b1;
    end
  end

  always_comb begin
    act_done = 1'b0;
    case (act_engine)
      2'd0:    act_done = eng_done[0];
      2'd1:    act_done = eng_done[1];
      2'd2:    act_done = eng_done[2];
      default: act_done = 1'b0;
    endcase
  end

  // Engines hold a stale done until they see start, so ARM masks done entirely.
  always_comb begin
    next_state  = state;
    pop         = 1'b0;
    eng_start   = 3'b000;
    cmd_retired = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = (head_engine == 2'd3) ? RETIRE : LAUNCH;
        end
      end
      LAUNCH: begin
        case (act_engine)
          2'd0:    eng_start = 3'b001;
          2'd1:    eng_start = 3'b010;
          2'd2:    eng_start = 3'b100;
          default: eng_start = 3'b000;
        endcase
        next_state = (ARM_CYCLES == 0) ? WAIT : ARM;
      end
      ARM: begin
        if (arm_cnt <= CW'(1)) next_state = WAIT;
      end
      WAIT: begin
        if (act_done) next_state = RETIRE;
      end
      RETIRE: begin
        cmd_retired = 1'b1;
        if (!empty) begin
          pop        = 1'b1;
          next_state = (head_engine == 2'd3) ? RETIRE : LAUNCH;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mux_x      = '0;
    mux_y      = '0;
    mux_colour = '0;
    mux_plot   = 1'b0;
    if (state == LAUNCH || state == ARM || state == WAIT) begin
      case (act_engine)
        2'd0: begin
          mux_x      = eng_vga_x[7:0];
          mux_y      = eng_vga_y[6:0];
          mux_colour = eng_vga_colour[2:0];
          mux_plot   = eng_vga_plot[0];
        end
        2'd1: begin
          mux_x      = eng_vga_x[15:8];
          mux_y      = eng_vga_y[13:7];
          mux_colour = eng_vga_colour[5:3];
          mux_plot   = eng_vga_plot[1];
        end
        2'd2: begin
          mux_x      = eng_vga_x[23:16];
          mux_y      = eng_vga_y[20:14];
          mux_colour = eng_vga_colour[8:6];
          mux_plot   = eng_vga_plot[2];
        end
        default: begin
          mux_x      = '0;
          mux_y      = '0;
          mux_colour = '0;
          mux_plot   = 1'b0;
        end
      endcase
    end
  end

  assign vga_x      = mux_x;
  assign vga_y      = mux_y;
  assign vga_colour = mux_colour;

`ifdef PLOT_CLIP_EN
  assign vga_plot = mux_plot && (mux_x <= 8'd159) && (mux_y <= 7'd119);
`else
  assign vga_plot = mux_plot;
`endif

  assign busy = (state != IDLE);
  assign idle = (state == IDLE) && empty;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed self-checking bench for draw_scheduler; the clip test runs only
// when PLOT_CLIP_EN is defined.
module tb_draw_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_engine;
  logic [2:0]  cmd_colour;
  logic [7:0]  cmd_cx;
  logic [6:0]  cmd_cy;
  logic [7:0]  cmd_diameter;
  logic [2:0]  eng_start;
  logic [2:0]  eng_done;
  logic [2:0]  eng_colour;
  logic [7:0]  eng_cx;
  logic [6:0]  eng_cy;
  logic [7:0]  eng_diameter;
  logic [23:0] eng_vga_x;
  logic [20:0] eng_vga_y;
  logic [8:0]  eng_vga_colour;
  logic [2:0]  eng_vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        idle;
  logic        cmd_retired;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  draw_scheduler #(.FIFO_DEPTH(4), .ARM_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_engine(cmd_engine),
    .cmd_colour(cmd_colour), .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .cmd_diameter(cmd_diameter),
    .eng_start(eng_start), .eng_done(eng_done), .eng_colour(eng_colour),
    .eng_cx(eng_cx), .eng_cy(eng_cy), .eng_diameter(eng_diameter),
    .eng_vga_x(eng_vga_x), .eng_vga_y(eng_vga_y), .eng_vga_colour(eng_vga_colour),
    .eng_vga_plot(eng_vga_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .idle(idle), .cmd_retired(cmd_retired)
  );

  // All stimulus changes and checks happen on the falling edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_engine = '0; cmd_colour = '0; cmd_cx = '0; cmd_cy = '0; cmd_diameter = '0;
    eng_done = '0; eng_vga_x = '0; eng_vga_y = '0; eng_vga_colour = '0; eng_vga_plot = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_cmd(input logic [1:0] e, input logic [2:0] c, input logic [7:0] x,
                         input logic [6:0] y, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_engine = e; cmd_colour = c; cmd_cx = x; cmd_cy = y; cmd_diameter = d;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b exp=1", cmd_ready); else passed++;
    checks++; if (idle !== 1'b1) $display("[TB] FAIL reset_idle got=%b exp=1", idle); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (eng_start !== 3'b000) $display("[TB] FAIL reset_start got=%b exp=000", eng_start); else passed++;
    checks++; if (cmd_retired !== 1'b0) $display("[TB] FAIL reset_retired got=%b exp=0", cmd_retired); else passed++;
    checks++; if ({vga_x, vga_y, vga_colour, vga_plot} !== 19'd0) $display("[TB] FAIL reset_vga got=%h exp=0", {vga_x, vga_y, vga_colour, vga_plot}); else passed++;
    checks++; if ({eng_colour, eng_cx, eng_cy, eng_diameter} !== 26'd0) $display("[TB] FAIL reset_latch got=%h exp=0", {eng_colour, eng_cx, eng_cy, eng_diameter}); else passed++;
  endtask

  task automatic test_single();
    do_reset();
    set_cmd(2'd2, 3'b100, 8'd80, 7'd60, 8'd40);
    step();
    cmd_valid = 1'b0;
    checks++; if (eng_start !== 3'b000) $display("[TB] FAIL single_start_early got=%b exp=000", eng_start); else passed++;
    checks++; if (idle !== 1'b0) $display("[TB] FAIL single_idle_queued got=%b exp=0", idle); else passed++;
    eng_vga_x = {8'd50, 8'd0, 8'd0}; eng_vga_y = {7'd30, 14'd0};
    eng_vga_colour = {3'b100, 6'd0}; eng_vga_plot = 3'b100;
    step();
    checks++; if (eng_start !== 3'b100) $display("[TB] FAIL single_start got=%b exp=100", eng_start); else passed++;
    checks++; if ({eng_colour, eng_cx, eng_cy, eng_diameter} !== {3'b100, 8'd80, 7'd60, 8'd40}) $display("[TB] FAIL single_latch got=%h exp=%h", {eng_colour, eng_cx, eng_cy, eng_diameter}, {3'b100, 8'd80, 7'd60, 8'd40}); else passed++;
    checks++; if ({vga_x, vga_y, vga_colour, vga_plot} !== {8'd50, 7'd30, 3'b100, 1'b1}) $display("[TB] FAIL single_vga got=%h exp=%h", {vga_x, vga_y, vga_colour, vga_plot}, {8'd50, 7'd30, 3'b100, 1'b1}); else passed++;
    step();
    checks++; if (eng_start !== 3'b000) $display("[TB] FAIL single_start_pulse got=%b exp=000", eng_start); else passed++;
    checks++; if (vga_x !== 8'd50) $display("[TB] FAIL single_vga_arm got=%0d exp=50", vga_x); else passed++;
    step(2);
    eng_done = 3'b100;
    step();
    checks++; if (cmd_retired !== 1'b1) $display("[TB] FAIL single_retired got=%b exp=1", cmd_retired); else passed++;
    checks++; if ({vga_x, vga_plot} !== 9'd0) $display("[TB] FAIL single_vga_retire got=%h exp=0", {vga_x, vga_plot}); else passed++;
    eng_done = 3'b000;
    step();
    checks++; if (cmd_retired !== 1'b0) $display("[TB] FAIL single_retired_once got=%b exp=0", cmd_retired); else passed++;
    checks++; if (idle !== 1'b1) $display("[TB] FAIL single_idle_end got=%b exp=1", idle); else passed++;
  endtask

  task automatic test_fifo_full();
    do_reset();
    set_cmd(2'd0, 3'b001, 8'd10, 7'd0, 8'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      set_cmd(2'd0, 3'b001, 8'(20 + k), 7'd0, 8'd0);
      checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL full_ready_%0d got=%b exp=1", k, cmd_ready); else passed++;
      step();
    end
    set_cmd(2'd0, 3'b001, 8'd30, 7'd0, 8'd0);
    checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL full_ready_drop got=%b exp=0", cmd_ready); else passed++;
    step(2);
    checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL full_ready_held got=%b exp=0", cmd_ready); else passed++;
    checks++; if (eng_cx !== 8'd10) $display("[TB] FAIL full_cx_stable got=%0d exp=10", eng_cx); else passed++;
    eng_done = 3'b001;
    step();
    checks++; if (cmd_retired !== 1'b1) $display("[TB] FAIL full_retired got=%b exp=1", cmd_retired); else passed++;
    checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL full_ready_retire got=%b exp=0", cmd_ready); else passed++;
    eng_done = 3'b000;
    step();
    checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL full_ready_after_pop got=%b exp=1", cmd_ready); else passed++;
    checks++; if (eng_cx !== 8'd20) $display("[TB] FAIL full_next_cx got=%0d exp=20", eng_cx); else passed++;
    checks++; if (eng_start !== 3'b001) $display("[TB] FAIL full_next_start got=%b exp=001", eng_start); else passed++;
    step();
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) $display("[TB] FAIL full_fifth_accepted got=%b exp=0", cmd_ready); else passed++;
  endtask

  task automatic test_stale_done();
    do_reset();
    eng_done = 3'b010;
    set_cmd(2'd1, 3'b010, 8'd5, 7'd6, 8'd7);
    step();
    cmd_valid = 1'b0;
    step();
    checks++; if (eng_start !== 3'b010) $display("[TB] FAIL stale_start got=%b exp=010", eng_start); else passed++;
    step();
    checks++; if (cmd_retired !== 1'b0) $display("[TB] FAIL stale_arm1 got=%b exp=0", cmd_retired); else passed++;
    step();
    checks++; if (cmd_retired !== 1'b0) $display("[TB] FAIL stale_arm2 got=%b exp=0", cmd_retired); else passed++;
    step();
    checks++; if (cmd_retired !== 1'b0) $display("[TB] FAIL stale_wait_entry got=%b exp=0", cmd_retired); else passed++;
    eng_done = 3'b000;
    step();
    checks++; if (busy !== 1'b1 || cmd_retired !== 1'b0) $display("[TB] FAIL stale_wait_low busy=%b retired=%b exp busy=1 retired=0", busy, cmd_retired); else passed++;
    eng_done = 3'b101;
    step();
    checks++; if (busy !== 1'b1 || cmd_retired !== 1'b0) $display("[TB] FAIL stale_other_done busy=%b retired=%b exp busy=1 retired=0", busy, cmd_retired); else passed++;
    eng_done = 3'b010;
    step();
    checks++; if (cmd_retired !== 1'b1) $display("[TB] FAIL stale_retire got=%b exp=1", cmd_retired); else passed++;
    eng_done = 3'b000;
    step();
    checks++; if (idle !== 1'b1) $display("[TB] FAIL stale_idle got=%b exp=1", idle); else passed++;
  endtask

  task automatic test_nop();
    do_reset();
    set_cmd(2'd0, 3'b001, 8'd1, 7'd0, 8'd0);
    step();
    set_cmd(2'd3, 3'b000, 8'd2, 7'd0, 8'd0);
    step();
    checks++; if (eng_start !== 3'b001 || eng_cx !== 8'd1) $display("[TB] FAIL nop_first_launch start=%b cx=%0d exp start=001 cx=1", eng_start, eng_cx); else passed++;
    set_cmd(2'd0, 3'b001, 8'd3, 7'd0, 8'd0);
    step();
    cmd_valid = 1'b0;
    step(2);
    eng_done = 3'b001;
    step();
    checks++; if (cmd_retired !== 1'b1 || eng_cx !== 8'd1) $display("[TB] FAIL nop_first_retire retired=%b cx=%0d exp retired=1 cx=1", cmd_retired, eng_cx); else passed++;
    eng_done = 3'b000;
    step();
    checks++; if (cmd_retired !== 1'b1 || eng_start !== 3'b000) $display("[TB] FAIL nop_retire retired=%b start=%b exp retired=1 start=000", cmd_retired, eng_start); else passed++;
    checks++; if (eng_cx !== 8'd2 || busy !== 1'b1) $display("[TB] FAIL nop_latch cx=%0d busy=%b exp cx=2 busy=1", eng_cx, busy); else passed++;
    step();
    checks++; if (eng_start !== 3'b001 || cmd_retired !== 1'b0) $display("[TB] FAIL nop_second_launch start=%b retired=%b exp start=001 retired=0", eng_start, cmd_retired); else passed++;
    checks++; if (eng_cx !== 8'd3) $display("[TB] FAIL nop_second_cx got=%0d exp=3", eng_cx); else passed++;
  endtask

  task automatic test_crosstalk();
    do_reset();
    set_cmd(2'd0, 3'b010, 8'd0, 7'd0, 8'd0);
    eng_vga_x = {8'd5, 8'd0, 8'd7}; eng_vga_y = {7'd5, 7'd0, 7'd8};
    eng_vga_colour = {3'b111, 3'b000, 3'b010}; eng_vga_plot = 3'b100;
    step();
    cmd_valid = 1'b0;
    checks++; if (vga_plot !== 1'b0 || vga_x !== 8'd0) $display("[TB] FAIL xtalk_idle plot=%b x=%0d exp plot=0 x=0", vga_plot, vga_x); else passed++;
    step();
    checks++; if ({vga_x, vga_y, vga_colour, vga_plot} !== {8'd7, 7'd8, 3'b010, 1'b0}) $display("[TB] FAIL xtalk_launch got=%h exp=%h", {vga_x, vga_y, vga_colour, vga_plot}, {8'd7, 7'd8, 3'b010, 1'b0}); else passed++;
    eng_vga_plot = 3'b101;
    #1;
    checks++; if (vga_plot !== 1'b1) $display("[TB] FAIL xtalk_follow got=%b exp=1", vga_plot); else passed++;
    eng_vga_plot = 3'b100;
    step();
    checks++; if (vga_plot !== 1'b0) $display("[TB] FAIL xtalk_arm got=%b exp=0", vga_plot); else passed++;
  endtask

`ifdef PLOT_CLIP_EN
  task automatic test_clip();
    do_reset();
    set_cmd(2'd0, 3'b001, 8'd0, 7'd0, 8'd0);
    eng_vga_x = {16'd0, 8'd160}; eng_vga_y = {14'd0, 7'd10}; eng_vga_plot = 3'b001;
    step();
    cmd_valid = 1'b0;
    step();
    checks++; if (vga_plot !== 1'b0 || vga_x !== 8'd160) $display("[TB] FAIL clip_x160 plot=%b x=%0d exp plot=0 x=160", vga_plot, vga_x); else passed++;
    eng_vga_x = {16'd0, 8'd159}; eng_vga_y = {14'd0, 7'd119};
    #1;
    checks++; if (vga_plot !== 1'b1) $display("[TB] FAIL clip_corner got=%b exp=1", vga_plot); else passed++;
    eng_vga_y = {14'd0, 7'd120};
    #1;
    checks++; if (vga_plot !== 1'b0 || vga_y !== 7'd120) $display("[TB] FAIL clip_y120 plot=%b y=%0d exp plot=0 y=120", vga_plot, vga_y); else passed++;
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    set_cmd(2'd0, 3'b011, 8'd9, 7'd9, 8'd9);
    eng_vga_x = {16'd0, 8'd9}; eng_vga_y = {14'd0, 7'd9}; eng_vga_colour = 9'd3; eng_vga_plot = 3'b001;
    step();
    set_cmd(2'd0, 3'b011, 8'd11, 7'd11, 8'd11);
    step();
    cmd_valid = 1'b0;
    step(3);
    checks++; if (busy !== 1'b1 || vga_plot !== 1'b1) $display("[TB] FAIL areset_pre busy=%b plot=%b exp busy=1 plot=1", busy, vga_plot); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || idle !== 1'b1 || cmd_ready !== 1'b1) $display("[TB] FAIL areset_state busy=%b idle=%b ready=%b exp 0 1 1", busy, idle, cmd_ready); else passed++;
    checks++; if ({vga_x, vga_y, vga_colour, vga_plot} !== 19'd0) $display("[TB] FAIL areset_vga got=%h exp=0", {vga_x, vga_y, vga_colour, vga_plot}); else passed++;
    checks++; if ({eng_colour, eng_cx, eng_cy, eng_diameter} !== 26'd0 || eng_start !== 3'b000) $display("[TB] FAIL areset_latch got=%h start=%b exp 0", {eng_colour, eng_cx, eng_cy, eng_diameter}, eng_start); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fifo_full();
    test_stale_done();
    test_nop();
    test_crosstalk();
`ifdef PLOT_CLIP_EN
    test_clip();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
